branch_predictor: RTL and testbench

- Fetch-side direction and target predictor, directly upstream of the IF stage.
- Performs a combinational lookup on the current fetch PC and drives pred_taken/pc_pred into the IF next-PC selection.
- Trained by control-flow resolution from EX.
- Organisation: direct-mapped BTB; each entry holds valid, tag, target and a 2-bit saturating direction counter.

---
 rtl/branch_predictor_pkg.sv | 42 ++++
 rtl/branch_predictor_sat_counter2.sv | 45 ++++
 rtl/branch_predictor.sv | 130 +++++++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Purpose : Shared types and constants for the fetch-side branch predictor.
//           Holds the BTB entry layout, the EX->IF training bundle, the
//           2-bit direction counter encodings, and a saturating increment
//           helper used by the statistics counters.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = 32 - BP_IDX_W - 2;

    // Direction counter encodings; the MSB is the predicted direction.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    // Logical layout of one BTB entry at the default table size.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
        logic [1:0]          ctr;
    } btb_entry_t;

    // Resolution information travelling from EX back to the predictor.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_update_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] satInc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Purpose : 2-bit saturating up/down counter with enable and parallel load.
//           One instance holds the direction state of one BTB entry.
// Ports   : clk       - core clock
//           rst       - synchronous active-high reset, counter -> weakly NT
//           i_en      - count one step this cycle
//           i_up      - direction of the step (1 = up, 0 = down)
//           i_load    - overwrite the counter with i_loadVal (wins over i_en)
//           i_loadVal - value used on load
//           o_ctr     - current counter value
// ---------------------------------------------------------------------------
import branch_predictor_pkg::*;

module sat_counter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [1:0] i_loadVal,
    output logic [1:0] o_ctr
);

    logic [1:0] r_ctr;

    // Counter saturates at both ends; load is used when an entry is
    // (re)allocated, so it takes priority over a count step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr <= CTR_WEAK_NT;
        end else if (i_load) begin
            r_ctr <= i_loadVal;
        end else if (i_en) begin
            if (i_up && (r_ctr != CTR_STRONG_T)) begin
                r_ctr <= r_ctr + 2'd1;
            end else if (!i_up && (r_ctr != CTR_STRONG_NT)) begin
                r_ctr <= r_ctr - 2'd1;
            end
        end
    end

    assign o_ctr = r_ctr;

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Purpose : Direct-mapped BTB with 2-bit direction counters. Looks up the
//           fetch PC combinationally and supplies the predicted next PC to
//           the IF next-PC mux; trained by branch/jump resolution from EX.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           pc_f                  - fetch PC to look up
//           pred_taken            - predicted taken (hit and counter MSB)
//           pc_pred               - predicted next PC (target or pc_f + 4)
//           pred_hit              - tag match on pc_f
//           upd_valid/pc/taken/target - training from EX
//           hit_cnt, upd_cnt      - saturating lookup-hit / update counters
// ---------------------------------------------------------------------------
import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int ENTRIES = BP_ENTRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pc_pred,
    output logic        pred_hit,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] hit_cnt,
    output logic [31:0] upd_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Flop-based storage so the lookup can be a plain asynchronous read.
    // Valid bits live in one vector so reset clears the table in a cycle.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         w_ctr    [ENTRIES];
    logic [31:0]        r_hitCnt;
    logic [31:0]        r_updCnt;

    bp_update_t         w_upd;
    logic [IDX_W-1:0]   w_lookupIdx;
    logic [TAG_W-1:0]   w_lookupTag;
    logic               w_lookupHit;
    logic [IDX_W-1:0]   w_updIdx;
    logic [TAG_W-1:0]   w_updTag;
    logic               w_updHit;
    logic               w_updWrite;
    logic               w_unused;

    assign w_upd = '{valid: upd_valid, pc: upd_pc, taken: upd_taken, target: upd_target};

    // Byte offset bits never take part in indexing or tagging.
    assign w_unused = &{1'b0, pc_f[1:0], w_upd.pc[1:0]};

    assign w_lookupIdx = pc_f[IDX_W+1:2];
    assign w_lookupTag = pc_f[31:IDX_W+2];
    assign w_updIdx    = w_upd.pc[IDX_W+1:2];
    assign w_updTag    = w_upd.pc[31:IDX_W+2];

    // Lookup is forced to a miss during reset so IF falls through to pc+4
    // even before the valid vector has been cleared.
    assign w_lookupHit = !rst && r_valid[w_lookupIdx] && (r_tag[w_lookupIdx] == w_lookupTag);
    assign pred_hit    = w_lookupHit;
    assign pred_taken  = w_lookupHit && w_ctr[w_lookupIdx][1];
    assign pc_pred     = pred_taken ? r_target[w_lookupIdx] : pc_f + 32'd4;

    // Any taken resolution writes the entry: a hit refreshes the target,
    // a miss allocates over whatever was there.
    assign w_updHit   = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_updWrite = !rst && w_upd.valid && w_upd.taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_updWrite) begin
            r_valid[w_updIdx] <= 1'b1;
        end
    end

    // Tags and targets are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_updWrite) begin
            r_target[w_updIdx] <= w_upd.target;
            if (!w_updHit) begin
                r_tag[w_updIdx] <= w_updTag;
            end
        end
    end

    // One direction counter per entry: counts on a training hit, loads
    // weakly-taken on allocation, untouched on a not-taken miss.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
        logic w_sel;
        assign w_sel = w_upd.valid && (w_updIdx == IDX_W'(gi));

        sat_counter2 u_ctr (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_sel && w_updHit),
            .i_up      (w_upd.taken),
            .i_load    (w_sel && !w_updHit && w_upd.taken),
            .i_loadVal (CTR_WEAK_T),
            .o_ctr     (w_ctr[gi])
        );
    end

    // Statistics counters, both saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hitCnt <= '0;
            r_updCnt <= '0;
        end else begin
            if (w_lookupHit) begin
                r_hitCnt <= satInc32(r_hitCnt);
            end
            if (w_upd.valid) begin
                r_updCnt <= satInc32(r_updCnt);
            end
        end
    end

    assign hit_cnt = r_hitCnt;
    assign upd_cnt = r_updCnt;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Purpose : Directed, scoreboard-checked bench for branch_predictor. Each
//           stimulus cycle pushes its hand-derived expected outputs; a
//           monitor pops and compares them half a cycle later.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] pred;
        logic [31:0] hitCnt;
        logic [31:0] updCnt;
    } expT;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        predTaken;
    logic [31:0] pcPred;
    logic        predHit;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic [31:0] hitCnt;
    logic [31:0] updCnt;

    expT         expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] tbHitCnt = 0;
    logic [31:0] tbUpdCnt = 0;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_f       (pcF),
        .pred_taken (predTaken),
        .pc_pred    (pcPred),
        .pred_hit   (predHit),
        .upd_valid  (updValid),
        .upd_pc     (updPc),
        .upd_taken  (updTaken),
        .upd_target (updTarget),
        .hit_cnt    (hitCnt),
        .upd_cnt    (updCnt)
    );

    // 10 ns core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    // Monitor: outputs are compared on the falling edge, away from updates.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput({e.name, ".pred_hit"},   {31'd0, predHit},   {31'd0, e.hit});
            checkOutput({e.name, ".pred_taken"}, {31'd0, predTaken}, {31'd0, e.taken});
            checkOutput({e.name, ".pc_pred"},    pcPred,             e.pred);
            checkOutput({e.name, ".hit_cnt"},    hitCnt,             e.hitCnt);
            checkOutput({e.name, ".upd_cnt"},    updCnt,             e.updCnt);
        end
    end

    // Drives one cycle of inputs and queues the expected response. The
    // statistics expectations follow from the hand-written hit expectation.
    task automatic applyStimulus(
        input string       name,
        input logic        doCheck,
        input logic        rstV,
        input logic [31:0] pc,
        input logic        uv,
        input logic [31:0] upc,
        input logic        ut,
        input logic [31:0] utgt,
        input logic        expHit,
        input logic        expTaken,
        input logic [31:0] expPred
    );
        expT e;
        @(posedge clk);
        #1;
        rst       = rstV;
        pcF       = pc;
        updValid  = uv;
        updPc     = upc;
        updTaken  = ut;
        updTarget = utgt;
        if (doCheck) begin
            e.name   = name;
            e.hit    = expHit;
            e.taken  = expTaken;
            e.pred   = expPred;
            e.hitCnt = tbHitCnt;
            e.updCnt = tbUpdCnt;
            expQ.push_back(e);
        end
        if (rstV) begin
            tbHitCnt = 0;
            tbUpdCnt = 0;
        end else begin
            if (expHit) tbHitCnt++;
            if (uv)     tbUpdCnt++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        pcF       = 32'h40;
        updValid  = 1'b0;
        updPc     = 32'h0;
        updTaken  = 1'b0;
        updTarget = 32'h0;

        //            name         chk rst pc            uv upc          ut tgt           hit tkn pred
        applyStimulus("rst0",      0,  1,  32'h40,       0, 32'h0,       0, 32'h0,        0,  0,  32'h44);
        applyStimulus("rst1",      1,  1,  32'h40,       0, 32'h0,       0, 32'h0,        0,  0,  32'h44);
        applyStimulus("cold",      1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        0,  0,  32'h44);
        applyStimulus("trainT",    1,  0,  32'h40,       1, 32'h40,      1, 32'h100,      0,  0,  32'h44);
        applyStimulus("hitT1",     1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        1,  1,  32'h100);
        applyStimulus("hitT2",     1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        1,  1,  32'h100);
        applyStimulus("nt1",       1,  0,  32'h40,       1, 32'h40,      0, 32'h0,        1,  1,  32'h100);
        applyStimulus("nt2",       1,  0,  32'h40,       1, 32'h40,      0, 32'h0,        1,  0,  32'h44);
        applyStimulus("ctr00",     1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        1,  0,  32'h44);
        applyStimulus("up1",       1,  0,  32'h40,       1, 32'h40,      1, 32'h100,      1,  0,  32'h44);
        applyStimulus("up2",       1,  0,  32'h40,       1, 32'h40,      1, 32'h100,      1,  0,  32'h44);
        applyStimulus("up3",       1,  0,  32'h40,       1, 32'h40,      1, 32'h140,      1,  1,  32'h100);
        applyStimulus("up4sat",    1,  0,  32'h40,       1, 32'h40,      1, 32'h140,      1,  1,  32'h140);
        applyStimulus("ntFrom11",  1,  0,  32'h40,       1, 32'h40,      0, 32'h0,        1,  1,  32'h140);
        applyStimulus("ctr10",     1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        1,  1,  32'h140);
        applyStimulus("aliasUpd",  1,  0,  32'h40,       1, 32'h80,      1, 32'h180,      1,  1,  32'h140);
        applyStimulus("aliasOld",  1,  0,  32'h40,       0, 32'h0,       0, 32'h0,        0,  0,  32'h44);
        applyStimulus("aliasNew",  1,  0,  32'h80,       0, 32'h0,       0, 32'h0,        1,  1,  32'h180);
        applyStimulus("ntMiss",    1,  0,  32'h200,      1, 32'h200,     0, 32'h0,        0,  0,  32'h204);
        applyStimulus("ntNoAlloc", 1,  0,  32'h200,      0, 32'h0,       0, 32'h0,        0,  0,  32'h204);
        applyStimulus("aliasKeep", 1,  0,  32'h80,       0, 32'h0,       0, 32'h0,        1,  1,  32'h180);
        applyStimulus("sameCyc",   1,  0,  32'h300,      1, 32'h300,     1, 32'h400,      0,  0,  32'h304);
        applyStimulus("nextCyc",   1,  0,  32'h300,      0, 32'h0,       0, 32'h0,        1,  1,  32'h400);
        applyStimulus("wrap",      1,  0,  32'hFFFFFFFC, 0, 32'h0,       0, 32'h0,        0,  0,  32'h0);
        applyStimulus("idx1Upd",   1,  0,  32'h1004,     1, 32'h1004,    1, 32'h2000,     0,  0,  32'h1008);
        applyStimulus("idx1Hit",   1,  0,  32'h1004,     0, 32'h0,       0, 32'h0,        1,  1,  32'h2000);
        applyStimulus("idx0Keep",  1,  0,  32'h300,      0, 32'h0,       0, 32'h0,        1,  1,  32'h400);
        applyStimulus("rstUpd",    1,  1,  32'h300,      1, 32'h500,     1, 32'h600,      0,  0,  32'h304);
        applyStimulus("postRst1",  1,  0,  32'h500,      0, 32'h0,       0, 32'h0,        0,  0,  32'h504);
        applyStimulus("postRst2",  1,  0,  32'h300,      0, 32'h0,       0, 32'h0,        0,  0,  32'h304);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
